// File: rtl/mem_stage_if.sv
// Pipeline link signals around the MEM stage: EXE->MEM handshake and MEM->WB handshake.
// slave is the MEM stage itself; master is whoever sits on the other side (EXE/WB or a bench).
interface mem_stage_if;
  logic         es_to_ms_valid;
  logic [158:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ms_to_ws_valid;
  logic [122:0] ms_to_ws_bus;
  logic         ws_allowin;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data SRAM response of loads/stores, aligns load
// data (incl. LWL/LWR merge), holds the response while WB stalls, and drops
// responses that belong to instructions killed by a WB flush.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  pipe,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_ex,
  input  logic        ws_eret,
  output logic [38:0] ms_to_ds_bus,
  output logic [31:0] ms_fwd_data,
  output logic        ms_ex_pending
);
  typedef struct packed {
    logic [31:0] rt_value;
    logic        mem_req;
    logic [2:0]  load_op;
    logic [31:0] badvaddr;
    logic [10:0] c0_bus;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic        ms_valid;
  es_bus_t     ms_bus;
  logic [1:0]  disc_cnt;
  logic [31:0] hold_data;

  logic flush, own_ok, ms_ready_go, accept, disc_inc, disc_dec, ms_load_pending;

  assign flush       = ws_ex || ws_eret;
  // Responses return in order, so while discards are owed the next data_ok is not ours.
  assign own_ok      = data_sram_data_ok && (disc_cnt == 2'd0);
  assign ms_ready_go = (state != S_WAIT) || own_ok;
  assign pipe.ms_allowin     = !ms_valid || (ms_ready_go && pipe.ws_allowin);
  assign pipe.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept      = pipe.es_to_ms_valid && pipe.ms_allowin && !flush;
  // A flushed WAIT leaves its response in flight unless it arrives in the same cycle.
  assign disc_inc    = flush && (state == S_WAIT) && !own_ok;
  assign disc_dec    = data_sram_data_ok && (disc_cnt != 2'd0);

  // Valid bit, wait/hold FSM and discard counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      state    <= S_IDLE;
      disc_cnt <= 2'd0;
    end else begin
      if (disc_inc && !disc_dec)      disc_cnt <= disc_cnt + 2'd1;
      else if (disc_dec && !disc_inc) disc_cnt <= disc_cnt - 2'd1;

      if (flush) begin
        ms_valid <= 1'b0;
        state    <= S_IDLE;
      end else begin
        if (pipe.ms_allowin) ms_valid <= pipe.es_to_ms_valid;
        if (accept) begin
          // bit 126 = mem_req, bit 78 = ex of the incoming bus
          state <= (pipe.es_to_ms_bus[126] && !pipe.es_to_ms_bus[78]) ? S_WAIT : S_IDLE;
        end else begin
          case (state)
            S_WAIT:  if (own_ok) state <= pipe.ws_allowin ? S_IDLE : S_HOLD;
            S_HOLD:  if (pipe.ws_allowin) state <= S_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

  // Instruction bus register and response holding register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_bus    <= '0;
      hold_data <= '0;
    end else begin
      if (accept) ms_bus <= pipe.es_to_ms_bus;
      if (!flush && state == S_WAIT && own_ok) hold_data <= data_sram_rdata;
    end
  end

  logic [1:0]  a;
  logic [31:0] w, rt, res;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [3:0]  we;

  assign a    = ms_bus.alu_result[1:0];
  assign w    = (state == S_HOLD) ? hold_data : data_sram_rdata;
  assign rt   = ms_bus.rt_value;
  assign hsel = a[1] ? w[31:16] : w[15:0];

  // Load alignment and LWL/LWR merge; everything else passes alu_result/rf_we through.
  always_comb begin
    bsel = w[7:0];
    case (a)
      2'd1:    bsel = w[15:8];
      2'd2:    bsel = w[23:16];
      2'd3:    bsel = w[31:24];
      default: ;
    endcase
    res = ms_bus.alu_result;
    we  = ms_bus.rf_we;
    if (ms_bus.mem_req && !ms_bus.ex) begin
      case (ms_bus.load_op)
        3'd1: res = {{24{bsel[7]}}, bsel};
        3'd2: res = {24'd0, bsel};
        3'd3: res = {{16{hsel[15]}}, hsel};
        3'd4: res = {16'd0, hsel};
        3'd5: res = w;
        3'd6: begin
          case (a)
            2'd0:    begin res = {w[7:0],  rt[23:0]}; we = 4'b1000; end
            2'd1:    begin res = {w[15:0], rt[15:0]}; we = 4'b1100; end
            2'd2:    begin res = {w[23:0], rt[7:0]};  we = 4'b1110; end
            default: begin res = w;                   we = 4'b1111; end
          endcase
        end
        3'd7: begin
          case (a)
            2'd0:    begin res = w;                    we = 4'b1111; end
            2'd1:    begin res = {rt[31:24], w[31:8]};  we = 4'b0111; end
            2'd2:    begin res = {rt[31:16], w[31:16]}; we = 4'b0011; end
            default: begin res = {rt[31:8],  w[31:24]}; we = 4'b0001; end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign pipe.ms_to_ws_bus = {ms_bus.badvaddr, ms_bus.c0_bus, ms_bus.bd, ms_bus.ex,
                              ms_bus.excode, we, ms_bus.dest, res, ms_bus.pc};

  assign ms_load_pending = ms_valid && (ms_bus.load_op != 3'd0) && (state == S_WAIT);
  // Low 28 bits are unused; forward data travels on ms_fwd_data.
  assign ms_to_ds_bus    = {ms_load_pending, we, ms_bus.dest, ms_valid, 28'd0};
  assign ms_fwd_data     = res;
  assign ms_ex_pending   = ms_valid && (ms_bus.ex || ms_bus.c0_bus[10]);

  // Flushes never outrun responses by three, so the counter must never reach 3.
  assert property (@(posedge clk) disable iff (!resetn) disc_cnt != 2'd3);
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, flush discard, WB backpressure, reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ws_ex, ws_eret;
  logic [38:0] ms_to_ds_bus;
  logic [31:0] ms_fwd_data;
  logic        ms_ex_pending;
  int checks = 0;
  int errors = 0;

  mem_stage_if pif();

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .pipe             (pif),
    .data_sram_data_ok(data_ok),
    .data_sram_rdata  (rdata),
    .ws_ex            (ws_ex),
    .ws_eret          (ws_eret),
    .ms_to_ds_bus     (ms_to_ds_bus),
    .ms_fwd_data      (ms_fwd_data),
    .ms_ex_pending    (ms_ex_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk_bus(input logic [31:0] rt, input logic mreq,
                                          input logic [2:0] op, input logic ex,
                                          input logic eret, input logic [3:0] we,
                                          input logic [31:0] alu);
    mk_bus = {rt, mreq, op, alu, eret, 10'd0, 1'b0, ex, 5'd0, we, 5'd7, alu, 32'hbfc0_0100};
  endfunction

  function automatic logic [31:0] res_of(input logic [122:0] b);
    res_of = b[63:32];
  endfunction

  function automatic logic [3:0] we_of(input logic [122:0] b);
    we_of = b[72:69];
  endfunction

  // Present one memory instruction, wait dly cycles, return rd, check WB output.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [31:0] rd, input int dly,
                         input logic [31:0] er, input logic [3:0] ew);
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(rt, 1'b1, op, 1'b0, 1'b0, 4'hf, alu);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      #2;
      chk({tag, "_wait_valid"}, pif.ms_to_ws_valid, 1'b0);
      chk({tag, "_wait_pending"}, ms_to_ds_bus[38], 1'b1);
      cyc;
    end
    data_ok = 1'b1;
    rdata   = rd;
    #2;
    chk({tag, "_valid"}, pif.ms_to_ws_valid, 1'b1);
    chk({tag, "_res"}, res_of(pif.ms_to_ws_bus), er);
    chk({tag, "_we"}, we_of(pif.ms_to_ws_bus), ew);
    cyc;
    data_ok = 1'b0;
    rdata   = 32'h0;
  endtask

  initial begin
    resetn = 1'b0;
    data_ok = 1'b0; rdata = '0; ws_ex = 1'b0; ws_eret = 1'b0;
    pif.es_to_ms_valid = 1'b0; pif.es_to_ms_bus = '0; pif.ws_allowin = 1'b1;
    #2;
    chk("rst_valid", pif.ms_to_ws_valid, 1'b0);
    chk("rst_allowin", pif.ms_allowin, 1'b1);
    chk("rst_ldpend", ms_to_ds_bus[38], 1'b0);
    chk("rst_expend", ms_ex_pending, 1'b0);
    cyc; cyc;
    resetn = 1'b1;
    cyc;

    // Loads of each kind with hand-computed alignment results.
    do_load("lb",    3'd1, 32'h1003, 32'h0,        32'h80FF_1234, 2, 32'hFFFF_FF80, 4'b1111);
    do_load("lwr2",  3'd7, 32'h2002, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_1122, 4'b0011);
    do_load("lwr3",  3'd7, 32'h2003, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'hAABB_CC11, 4'b0001);
    do_load("lwl0",  3'd6, 32'h2000, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h44BB_CCDD, 4'b1000);
    do_load("lwl1",  3'd6, 32'h2001, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h3344_CCDD, 4'b1100);
    do_load("lh2",   3'd3, 32'h3002, 32'h0,        32'h8001_1234, 0, 32'hFFFF_8001, 4'b1111);
    do_load("lbu1",  3'd2, 32'h3001, 32'h0,        32'h80FF_1234, 0, 32'h0000_0012, 4'b1111);
    do_load("lhu0",  3'd4, 32'h3000, 32'h0,        32'h8001_8234, 0, 32'h0000_8234, 4'b1111);
    do_load("lw",    3'd5, 32'h3004, 32'h0,        32'h1234_5678, 1, 32'h1234_5678, 4'b1111);

    // Non-memory instruction passes straight through with its full bus.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 4'b0101, 32'h1234_5678);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    #2;
    chk("alu_valid", pif.ms_to_ws_valid, 1'b1);
    chk("alu_bus", pif.ms_to_ws_bus,
        {32'h1234_5678, 11'd0, 1'b0, 1'b0, 5'd0, 4'b0101, 5'd7, 32'h1234_5678, 32'hbfc0_0100});
    chk("alu_fwd", ms_fwd_data, 32'h1234_5678);
    cyc;
    chk("alu_drain", pif.ms_to_ws_valid, 1'b0);

    // Flush in WAIT: the stale response must be discarded, the next one delivered.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b1, 3'd5, 1'b0, 1'b0, 4'hf, 32'h100);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    ws_ex = 1'b1;
    cyc;
    ws_ex = 1'b0;
    #2;
    chk("fl_cleared", pif.ms_to_ws_valid, 1'b0);
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b1, 3'd5, 1'b0, 1'b0, 4'hf, 32'h104);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    #2;
    chk("fl_stale_valid", pif.ms_to_ws_valid, 1'b0);
    cyc;
    rdata = 32'h0000_0042;
    #2;
    chk("fl_new_valid", pif.ms_to_ws_valid, 1'b1);
    chk("fl_new_res", res_of(pif.ms_to_ws_bus), 32'h0000_0042);
    cyc;
    data_ok = 1'b0; rdata = '0;
    #2;
    chk("fl_drain", pif.ms_to_ws_valid, 1'b0);
    cyc;

    // Flush coincident with data_ok: counter stays 0, next load completes on its own response.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b1, 3'd5, 1'b0, 1'b0, 4'hf, 32'h108);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'h1111_1111; ws_eret = 1'b1;
    cyc;
    data_ok = 1'b0; ws_eret = 1'b0;
    do_load("fl_same", 3'd5, 32'h10C, 32'h0, 32'h0000_0099, 0, 32'h0000_0099, 4'b1111);

    // WB backpressure: response parked in HOLD, survives rdata changes.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b1, 3'd5, 1'b0, 1'b0, 4'hf, 32'h200);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    pif.ws_allowin = 1'b0;
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    #2;
    chk("hold_ok_valid", pif.ms_to_ws_valid, 1'b1);
    chk("hold_ok_allowin", pif.ms_allowin, 1'b0);
    cyc;
    data_ok = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hold_valid", pif.ms_to_ws_valid, 1'b1);
      chk("hold_res", res_of(pif.ms_to_ws_bus), 32'hCAFE_F00D);
      chk("hold_allowin", pif.ms_allowin, 1'b0);
      if (i == 0) chk("hold_state", dut.state, 2);
      cyc;
    end
    pif.ws_allowin = 1'b1;
    #2;
    chk("hold_rel_allowin", pif.ms_allowin, 1'b1);
    cyc;
    #2;
    chk("hold_rel_valid", pif.ms_to_ws_valid, 1'b0);
    cyc;

    // Exception-tagged memory op: no wait, ex_pending raised, passes next cycle.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b1, 3'd5, 1'b1, 1'b0, 4'hf, 32'hBADC_0DE0);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    #2;
    chk("ex_valid", pif.ms_to_ws_valid, 1'b1);
    chk("ex_pending", ms_ex_pending, 1'b1);
    chk("ex_ldpend", ms_to_ds_bus[38], 1'b0);
    chk("ex_res", res_of(pif.ms_to_ws_bus), 32'hBADC_0DE0);
    cyc;
    chk("ex_gone", ms_ex_pending, 1'b0);

    // eret marker in c0_bus also raises ex_pending.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 4'h0, 32'h0);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    #2;
    chk("eret_pending", ms_ex_pending, 1'b1);
    cyc;

    // Reset mid-WAIT: outstanding response forgotten, stray data_ok ignored.
    pif.es_to_ms_valid = 1'b1;
    pif.es_to_ms_bus   = mk_bus(32'h0, 1'b1, 3'd5, 1'b0, 1'b0, 4'hf, 32'h300);
    cyc;
    pif.es_to_ms_valid = 1'b0;
    resetn = 1'b0;
    #2;
    chk("rw_valid", pif.ms_to_ws_valid, 1'b0);
    chk("rw_allowin", pif.ms_allowin, 1'b1);
    chk("rw_ldpend", ms_to_ds_bus[38], 1'b0);
    cyc;
    resetn = 1'b1;
    data_ok = 1'b1; rdata = 32'h0000_0777;
    #2;
    chk("rw_stray", pif.ms_to_ws_valid, 1'b0);
    chk("rw_state", dut.state, 0);
    cyc;
    data_ok = 1'b0;
    do_load("rw_next", 3'd5, 32'h304, 32'h0, 32'h0000_0055, 0, 32'h0000_0055, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ws_allowin  in  1  WB accepts this cycle; ms_allowin  out  1  MEM accepts from EXE.
REQ-004 SHALL have ports: es_to_ms_valid  in  1; es_to_ms_bus  in  159  {rt_value[158:127], mem_req[126], load_op[125:123], badvaddr[122:91], c0_bus[90:80], bd[79], ex[78], excode[77:73], rf_we[72:69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-005 SHALL have ports: ms_to_ws_valid  out  1; ms_to_ws_bus  out  123  same layout as bits 122:0 above, with bits 63:32 carrying the final result.
REQ-006 SHALL have ports: data_sram_data_ok  in  1  read/write response; data_sram_rdata  in  32  load data, valid with data_ok.
REQ-007 SHALL have ports: ms_to_ds_bus  out  39  {ms_load_pending[38], rf_we[37:34], dest[33:29], ms_valid_fwd[28]... ; forward data in bits 31:0 of a separate 32-bit port ms_fwd_data}.
REQ-008 SHALL have ports: ws_ex  in  1, ws_eret  in  1  flush requests from WB; ms_ex_pending  out  1  MEM holds a valid exception or eret (EXE suppresses new stores).
REQ-009 Parameter: none; load_op encoding fixed: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.

Function
REQ-010 ms_valid and bus register SHALL load on es_to_ms_valid && ms_allowin; ms_valid cleared on ms_allowin with no input.
REQ-011 FSM states SHALL be IDLE, WAIT (mem_req issued, data_ok not seen), HOLD (response captured, WB not accepting).
REQ-012 IDLE->WAIT on accepted instruction with mem_req=1 and ex=0; WAIT->IDLE on data_ok && ws_allowin; WAIT->HOLD on data_ok && !ws_allowin; HOLD->IDLE on ws_allowin.
REQ-013 data_sram_rdata SHALL be captured into a 32-bit holding register on the data_ok cycle in WAIT.
REQ-014 ms_ready_go SHALL be 1 in IDLE and HOLD, 1 in WAIT only when data_ok; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-015 ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-016 Load result, a = alu_result[1:0]: LB/LBU sign/zero-extend byte a; LH/LHU sign/zero-extend halfword a[1]; LW full word.
REQ-017 LWL SHALL merge memory bytes into rt_value high bytes, output rf_we masks 1000/1100/1110/1111 for a=0..3; LWR masks 1111/0111/0011/0001 for a=0..3.
REQ-018 Non-load instructions SHALL pass alu_result and rf_we unchanged.
REQ-019 Flush (ws_ex || ws_eret) SHALL clear ms_valid next edge regardless of state.
REQ-020 Flush while in WAIT SHALL increment a 2-bit discard counter; each later data_ok while counter>0 SHALL decrement it and be ignored, not captured.
REQ-021 New instruction with mem_req accepted while discard counter>0 SHALL stay in WAIT until its own (non-discarded) data_ok.
REQ-022 Discard counter saturation at 3 SHALL not occur by construction; reaching 3 is a verification error.
REQ-023 ms_load_pending = ms_valid && load_op!=0 && state==WAIT; DS stalls on dest match.
REQ-024 ms_ex_pending = ms_valid && (ex || c0_bus[10]).
REQ-025 Simultaneous flush and data_ok in WAIT: data is discarded, counter unchanged.

Reset
REQ-026 On resetn low, asynchronously: ms_valid=0, state=IDLE, discard counter=0, holding register=0, bus register=0.
REQ-027 During reset all outputs SHALL read: ms_to_ws_valid=0, ms_allowin=1, ms_load_pending=0, ms_ex_pending=0.
REQ-028 Reset asserted mid-WAIT SHALL drop any outstanding response; no discard tracking survives reset.

Verification
REQ-029 LB at alu_result=0x1003, rdata=0x80FF_1234, data_ok after 2 cycles -> ms_to_ws result 0xFFFF_FF80, rf_we 1111, valid on data_ok cycle.
REQ-030 LWR a=2, rt=0xAABB_CCDD, rdata=0x1122_3344 -> result 0xAABB_1122, rf_we 0011.
REQ-031 LW in WAIT, ws_ex pulse, then LW2 accepted; first data_ok 0xDEAD_BEEF discarded, second 0x0000_0042 -> WB sees only 0x42.
REQ-032 data_ok with ws_allowin=0 for 3 cycles -> state HOLD, data retained, ms_allowin=0, released when ws_allowin=1.
REQ-033 Instruction with ex=1, mem_req=1 -> no WAIT entry, ms_ex_pending=1, passes to WB next cycle.
REQ-034 resetn low mid-WAIT then high -> ms_to_ws_valid=0, state IDLE, stray data_ok ignored.
